// File: rtl/incoming_response_buffer_if.sv
// AXI R-channel beat handshake bundle used on both sides of the response buffer.
// master drives valid and payload; slave drives ready.
interface incoming_response_buffer_if #(
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 64,
    parameter int RESP_WIDTH = 2
);
    logic                  valid;
    logic                  ready;
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] data;
    logic [RESP_WIDTH-1:0] resp;
    logic                  last;

    modport master (output valid, id, data, resp, last, input ready);
    modport slave  (input valid, id, data, resp, last, output ready);
endinterface

// File: rtl/incoming_response_buffer.sv
// In-order beat FIFO for returning AXI R responses, with burst count and sticky error flag.
// Define INCOMING_RESP_SF_EN for store-and-forward release (forced cut-through when full).
module incoming_response_buffer #(
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 64,
    parameter int RESP_WIDTH = 2,
    parameter int DEPTH      = 16,
    localparam int PTR_W     = $clog2(DEPTH),
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    incoming_response_buffer_if.slave   r_in,
    incoming_response_buffer_if.master  r_out,
    output logic [CNT_W-1:0]            beat_count,
    output logic [CNT_W-1:0]            burst_count,
    output logic                        err_seen,
    input  logic                        err_clr
);
    localparam int E_W = ID_WIDTH + DATA_WIDTH + RESP_WIDTH + 1;

    logic [E_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [E_W-1:0]   head;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    assign full  = (beat_count == CNT_W'(DEPTH));
    assign empty = (beat_count == '0);
    assign push  = r_in.valid & ~full;
    assign pop   = r_out.valid & r_out.ready;

    assign r_in.ready = ~full;
    assign head       = empty ? '0 : mem[rd_ptr];
    assign {r_out.id, r_out.data, r_out.resp, r_out.last} = head;

`ifdef INCOMING_RESP_SF_EN
    // drain keeps a head burst flowing once forced cut-through has started releasing it
    logic drain;

    assign r_out.valid = ~empty & ((burst_count != '0) | full | drain);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drain <= 1'b0;
        end else if (pop) begin
            drain <= ~r_out.last;
        end
    end
`else
    assign r_out.valid = ~empty;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {r_in.id, r_in.data, r_in.resp, r_in.last};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            beat_count  <= '0;
            burst_count <= '0;
            err_seen    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   beat_count <= beat_count + CNT_W'(1);
                2'b01:   beat_count <= beat_count - CNT_W'(1);
                default: beat_count <= beat_count;
            endcase
            case ({push & r_in.last, pop & r_out.last})
                2'b10:   burst_count <= burst_count + CNT_W'(1);
                2'b01:   burst_count <= burst_count - CNT_W'(1);
                default: burst_count <= burst_count;
            endcase
            // a new error in the same cycle as a clear must not be lost
            if (push & r_in.resp[1]) begin
                err_seen <= 1'b1;
            end else if (err_clr) begin
                err_seen <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_incoming_response_buffer.sv
// Directed self-checking bench for incoming_response_buffer (cut-through by default,
// store-and-forward scenarios when INCOMING_RESP_SF_EN is defined).
module tb_incoming_response_buffer;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       err_clr = 1'b0;
    logic [4:0] beat_count;
    logic [4:0] burst_count;
    logic       err_seen;
    int         total = 0;
    int         bad = 0;

    incoming_response_buffer_if #(.ID_WIDTH(4), .DATA_WIDTH(64), .RESP_WIDTH(2)) r_in_if ();
    incoming_response_buffer_if #(.ID_WIDTH(4), .DATA_WIDTH(64), .RESP_WIDTH(2)) r_out_if ();

    incoming_response_buffer #(
        .ID_WIDTH(4), .DATA_WIDTH(64), .RESP_WIDTH(2), .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .r_in(r_in_if),
        .r_out(r_out_if),
        .beat_count(beat_count),
        .burst_count(burst_count),
        .err_seen(err_seen),
        .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [63:0] d, input logic [1:0] rsp, input logic lst);
        r_in_if.valid = v;
        r_in_if.id    = 4'd2;
        r_in_if.data  = d;
        r_in_if.resp  = rsp;
        r_in_if.last  = lst;
    endtask

    initial begin
        int pi;
        int po;
        int first_pop_cnt;
        drive(1'b0, 64'h0, 2'b00, 1'b0);
        r_out_if.ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 64'(r_in_if.ready), 64'd1);
        chk("rst_valid", 64'(r_out_if.valid), 64'd0);
        chk("rst_beats", 64'(beat_count), 64'd0);
        chk("rst_bursts", 64'(burst_count), 64'd0);
        chk("rst_err", 64'(err_seen), 64'd0);
        chk("rst_data", r_out_if.data, 64'd0);
        rst = 1'b0;
        step();

`ifndef INCOMING_RESP_SF_EN
        // three-beat burst straight through
        r_out_if.ready = 1'b1;
        drive(1'b1, 64'hA0, 2'b00, 1'b0);
        chk("t1_no_valid_before", 64'(r_out_if.valid), 64'd0);
        step();
        chk("t1_valid_after_1", 64'(r_out_if.valid), 64'd1);
        chk("t1_head0", r_out_if.data, 64'hA0);
        chk("t1_id0", 64'(r_out_if.id), 64'd2);
        drive(1'b1, 64'hA1, 2'b00, 1'b0);
        step();
        chk("t1_head1", r_out_if.data, 64'hA1);
        chk("t1_cnt1", 64'(beat_count), 64'd1);
        drive(1'b1, 64'hA2, 2'b00, 1'b1);
        step();
        chk("t1_head2", r_out_if.data, 64'hA2);
        chk("t1_burst1", 64'(burst_count), 64'd1);
        chk("t1_last2", 64'(r_out_if.last), 64'd1);
        drive(1'b0, 64'h0, 2'b00, 1'b0);
        step();
        chk("t1_cnt0", 64'(beat_count), 64'd0);
        chk("t1_burst0", 64'(burst_count), 64'd0);
        chk("t1_empty_valid", 64'(r_out_if.valid), 64'd0);

        // fill to DEPTH, hold the 17th beat, pop one, then accept it
        r_out_if.ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 64'h100 + 64'(i), 2'b00, (i == 7) || (i == 15));
            step();
        end
        chk("t2_full_ready", 64'(r_in_if.ready), 64'd0);
        chk("t2_full_cnt", 64'(beat_count), 64'd16);
        chk("t2_full_bursts", 64'(burst_count), 64'd2);
        drive(1'b1, 64'h110, 2'b00, 1'b1);
        step();
        chk("t2_held_cnt", 64'(beat_count), 64'd16);
        chk("t2_head_full", r_out_if.data, 64'h100);
        r_out_if.ready = 1'b1;
        step();
        r_out_if.ready = 1'b0;
        chk("t2_pop_ready", 64'(r_in_if.ready), 64'd1);
        chk("t2_pop_cnt", 64'(beat_count), 64'd15);
        step();
        drive(1'b0, 64'h0, 2'b00, 1'b0);
        chk("t2_17th_cnt", 64'(beat_count), 64'd16);
        chk("t2_17th_bursts", 64'(burst_count), 64'd3);
        r_out_if.ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk("t2_drain_data", r_out_if.data, 64'h101 + 64'(i));
            step();
        end
        chk("t2_drain_cnt", 64'(beat_count), 64'd0);
        chk("t2_drain_bursts", 64'(burst_count), 64'd0);

        // 40 beats of simultaneous push/pop at half full, pointers wrap repeatedly
        r_out_if.ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 64'h200 + 64'(i), 2'b00, 1'b0);
            step();
        end
        r_out_if.ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            chk("t3_stream_data", r_out_if.data, 64'h200 + 64'(k));
            chk("t3_stream_cnt", 64'(beat_count), 64'd8);
            drive(1'b1, 64'h208 + 64'(k), 2'b00, 1'b0);
            step();
        end
        drive(1'b0, 64'h0, 2'b00, 1'b0);
        for (int j = 0; j < 8; j++) begin
            chk("t3_tail_data", r_out_if.data, 64'h228 + 64'(j));
            step();
        end
        chk("t3_tail_cnt", 64'(beat_count), 64'd0);
`else
        // store-and-forward: nothing released until the last beat is buffered
        r_out_if.ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 64'hB0 + 64'(i), 2'b00, 1'b0);
            step();
            chk("sf_hold_valid", 64'(r_out_if.valid), 64'd0);
        end
        drive(1'b1, 64'hB3, 2'b00, 1'b1);
        step();
        drive(1'b0, 64'h0, 2'b00, 1'b0);
        chk("sf_release_valid", 64'(r_out_if.valid), 64'd1);
        for (int i = 0; i < 4; i++) begin
            chk("sf_release_data", r_out_if.data, 64'hB0 + 64'(i));
            step();
        end
        chk("sf_release_cnt", 64'(beat_count), 64'd0);

        // 20-beat burst larger than DEPTH must cut through at full
        pi = 0;
        po = 0;
        first_pop_cnt = -1;
        for (int cyc = 0; cyc < 200 && po < 20; cyc++) begin
            drive(pi < 20, 64'h300 + 64'(pi), 2'b00, pi == 19);
            if (r_out_if.valid) begin
                if (first_pop_cnt < 0) first_pop_cnt = int'(beat_count);
                chk("sf_big_data", r_out_if.data, 64'h300 + 64'(po));
                po++;
            end
            if (r_in_if.valid && r_in_if.ready) pi++;
            step();
        end
        drive(1'b0, 64'h0, 2'b00, 1'b0);
        chk("sf_big_delivered", 64'(po), 64'd20);
        chk("sf_big_first_at_full", 64'(first_pop_cnt), 64'd16);
        chk("sf_big_empty_valid", 64'(r_out_if.valid), 64'd0);
        chk("sf_big_bursts", 64'(burst_count), 64'd0);
`endif

        // sticky error flag
        r_out_if.ready = 1'b1;
        drive(1'b1, 64'hC0, 2'b01, 1'b1);
        step();
        chk("err_okay_resp01", 64'(err_seen), 64'd0);
        drive(1'b1, 64'hC1, 2'b10, 1'b1);
        step();
        chk("err_set", 64'(err_seen), 64'd1);
        drive(1'b1, 64'hC2, 2'b11, 1'b1);
        err_clr = 1'b1;
        step();
        chk("err_set_wins", 64'(err_seen), 64'd1);
        drive(1'b0, 64'h0, 2'b00, 1'b0);
        step();
        err_clr = 1'b0;
        chk("err_cleared", 64'(err_seen), 64'd0);
        step();
        chk("err_drained_cnt", 64'(beat_count), 64'd0);

        // reset with a partial burst held
        r_out_if.ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 64'hD0 + 64'(i), 2'b00, 1'b0);
            step();
        end
        drive(1'b0, 64'h0, 2'b00, 1'b0);
        chk("rmid_cnt5", 64'(beat_count), 64'd5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rmid_cnt", 64'(beat_count), 64'd0);
        chk("rmid_bursts", 64'(burst_count), 64'd0);
        chk("rmid_valid", 64'(r_out_if.valid), 64'd0);
        chk("rmid_ready", 64'(r_in_if.ready), 64'd1);
        chk("rmid_data", r_out_if.data, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/incoming_response_buffer.md
# incoming_response_buffer

Beat-level FIFO for AXI R-channel responses returning from the AXI slave toward the response reordering logic; the return-path counterpart of the outgoing AR request buffer. It accepts R beats from the slave, holds them in order, and presents the oldest beat downstream. It also tracks how many complete bursts are buffered and keeps a sticky error flag for non-OKAY responses.

## Interface
- ID_WIDTH, 4, AXI ID width
- DATA_WIDTH, 64, R data width
- RESP_WIDTH, 2, RRESP width
- DEPTH, 16, beat entries (≥2); PTR_W = $clog2(DEPTH), CNT_W = $clog2(DEPTH+1)

- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- r_in.valid  in  1  beat valid from slave
- r_in.ready  out  1  buffer can accept a beat
- r_in.id / data / resp / last  in  ID_WIDTH / DATA_WIDTH / RESP_WIDTH / 1  beat payload
- r_out.valid  out  1  head beat available
- r_out.ready  in  1  downstream accepts head beat
- r_out.id / data / resp / last  out  ID_WIDTH / DATA_WIDTH / RESP_WIDTH / 1  head beat payload
- beat_count  out  CNT_W  beats held
- burst_count  out  CNT_W  complete bursts held (beats with last=1 held)
- err_seen  out  1  sticky: any accepted beat had resp[1]=1 (SLVERR/DECERR)
- err_clr  in  1  synchronous clear of err_seen

## Operation
- push = r_in.valid & r_in.ready; pop = r_out.valid & r_out.ready.
- r_in.ready = ~full (full: beat_count == DEPTH). No same-cycle bypass when full: a pop while full does not enable a push that cycle.
- Push writes {id,data,resp,last} to mem[wr_ptr]; wr_ptr increments, wraps DEPTH-1 → 0 (DEPTH need not be a power of two).
- Pop advances rd_ptr with identical wrap rule.
- beat_count: +1 push only, −1 pop only, unchanged for both or neither.
- burst_count: +1 on push with r_in.last=1, −1 on pop with r_out.last=1; both in same cycle → unchanged.
- r_out payload = mem[rd_ptr] when non-empty; all-zero when empty.
- err_seen: set on push with r_in.resp[1]=1; err_clr=1 clears. Set and clear in the same cycle → set wins (err_seen=1).
- Beat order strictly preserved; no reordering by ID inside this block.

## Timing
- Reset (async): wr_ptr=rd_ptr=0, beat_count=0, burst_count=0, err_seen=0; hence r_in.ready=1, r_out.valid=0, r_out payload=0. mem contents not reset.
- Reset mid-burst discards all held beats; partially received bursts are dropped, no recovery.
- Latency: beat pushed at edge N is visible on r_out from cycle N+1 (if it is the head); minimum one cycle through.
- Throughput: one push and one pop per cycle sustained when neither full nor empty.
- r_in.ready, r_out.valid, beat_count, burst_count derived from registered state only; r_out.valid never depends combinationally on r_out.ready.
- Full: r_in.ready=0; r_in.valid held by slave per AXI, payload unchanged.
- Empty: r_out.valid=0 regardless of r_out.ready.

## Configuration
- INCOMING_RESP_SF_EN defined: store-and-forward. r_out.valid = ~empty & ((burst_count != 0) | full). Beats of a burst are released only once its last beat is buffered; the full term forces cut-through when one burst exceeds DEPTH, preventing deadlock. Once the head burst starts draining under forced cut-through, release continues while non-empty until its last beat pops (one-bit drain flag, cleared on pop with last=1, cleared on reset).
- Not defined: cut-through; r_out.valid = ~empty. burst_count still maintained.

## Test plan
- Reset then push 3 beats (id=2, data=0xA0..0xA2, last on third), r_out.ready=1 → popped in order, first r_out.valid one cycle after first push, beat_count back to 0, burst_count 1→0.
- Fill DEPTH=16 beats with r_out.ready=0 → r_in.ready=0 after 16th push, beat_count=16; 17th beat held by slave not lost; one pop → ready=1 next cycle, 17th beat accepted.
- Continuous push+pop for 40 beats at half-full → beat_count constant, pointers wrap past 15 correctly, data order intact.
- Push beat with resp=2'b10 → err_seen=1 next cycle; err_clr pulse in same cycle as another resp=2'b11 push → err_seen stays 1; later lone err_clr → 0.
- With INCOMING_RESP_SF_EN: push 3 beats last=0 → r_out.valid=0; push last beat → r_out.valid=1 next cycle. 20-beat burst into DEPTH=16 → forced cut-through at full, all 20 beats delivered in order, no deadlock.
- Assert rst mid-burst with 5 beats held → next cycle beat_count=0, burst_count=0, r_out.valid=0, r_in.ready=1.
